// File: rtl/jump_target_unit_if.sv
// Request/response bundle for the jump target unit: request side is
// in_valid/in_ready, result side is out_valid/out_ready.
interface jump_target_unit_if #(
  parameter int word_size    = 32,
  parameter int offset_width = 26
);
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              mode;
  logic                    link;
  logic                    flush;
  logic [word_size-1:0]    inputPC;
  logic [offset_width-1:0] offset;
  logic [word_size-1:0]    reg_target;
  logic                    out_valid;
  logic                    out_ready;
  logic [word_size-1:0]    jump_target;
  logic                    misaligned;
  logic                    ras_underflow;
  logic                    ras_overflow;

  modport master (
    output in_valid, mode, link, flush, inputPC, offset, reg_target, out_ready,
    input  in_ready, out_valid, jump_target, misaligned, ras_underflow, ras_overflow
  );

  modport slave (
    input  in_valid, mode, link, flush, inputPC, offset, reg_target, out_ready,
    output in_ready, out_valid, jump_target, misaligned, ras_underflow, ras_overflow
  );
endinterface

// File: rtl/jump_target_unit.sv
// Jump target computation (PC-relative, region, indirect, return) with a
// circular return-address stack and a one-entry registered result stage.
module jump_target_unit #(
  parameter int word_size    = 32,
  parameter int offset_width = 26,
  parameter int shift_amt    = 2,
  parameter int ras_depth    = 4
) (
  input logic              clk,
  input logic              reset,
  jump_target_unit_if.slave bus
);
  localparam int ptr_w = $clog2(ras_depth);
  localparam int cnt_w = $clog2(ras_depth + 1);
  localparam logic [cnt_w-1:0]     cnt_full    = cnt_w'(ras_depth);
  localparam logic [word_size-1:0] region_mask = {word_size{1'b1}} << (offset_width + shift_amt);
  localparam logic [word_size-1:0] align_mask  = ~({word_size{1'b1}} << shift_amt);

  logic                 out_valid_d, out_valid_q;
  logic [word_size-1:0] jump_target_d, jump_target_q;
  logic                 misaligned_d, misaligned_q;
  logic                 ras_underflow_d, ras_underflow_q;
  logic                 ras_overflow_d, ras_overflow_q;
  logic [ptr_w-1:0]     ras_ptr_d, ras_ptr_q;
  logic [cnt_w-1:0]     ras_cnt_d, ras_cnt_q;
  logic [word_size-1:0] ras_mem_d [ras_depth];
  logic [word_size-1:0] ras_mem_q [ras_depth];

  logic                 in_ready;
  logic                 accept;
  logic                 ras_empty, ras_full, do_pop;
  logic [ptr_w-1:0]     top_idx;
  logic [word_size-1:0] ext, region, ret_addr, target;

  assign in_ready  = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && in_ready && !bus.flush;
  assign ras_empty = (ras_cnt_q == '0);
  assign ras_full  = (ras_cnt_q == cnt_full);
  assign do_pop    = (bus.mode == 2'b11) && !ras_empty;
  // ras_ptr_q points at the next free slot; the top lives one below it.
  assign top_idx   = ras_ptr_q - ptr_w'(1);
  assign ret_addr  = bus.inputPC + word_size'(4);
  assign ext       = {{(word_size-offset_width){bus.offset[offset_width-1]}}, bus.offset} << shift_amt;
  assign region    = (bus.inputPC & region_mask)
                   | ({{(word_size-offset_width){1'b0}}, bus.offset} << shift_amt);

  always_comb begin
    target = bus.reg_target;
    unique case (bus.mode)
      2'b00:   target = bus.inputPC + ext;
      2'b01:   target = region;
      2'b10:   target = bus.reg_target;
      default: target = do_pop ? ras_mem_q[top_idx] : bus.reg_target;
    endcase
  end

  always_comb begin
    out_valid_d     = out_valid_q;
    jump_target_d   = jump_target_q;
    misaligned_d    = misaligned_q;
    ras_underflow_d = ras_underflow_q;
    ras_overflow_d  = ras_overflow_q;
    ras_ptr_d       = ras_ptr_q;
    ras_cnt_d       = ras_cnt_q;
    ras_mem_d       = ras_mem_q;

    if (accept) begin
      out_valid_d     = 1'b1;
      jump_target_d   = target;
      misaligned_d    = (target & align_mask) != '0;
      ras_underflow_d = (bus.mode == 2'b11) && ras_empty;
      ras_overflow_d  = bus.link && ras_full && !do_pop;

      // Pop+push collapses into an in-place overwrite of the top slot.
      if (do_pop && bus.link) begin
        ras_mem_d[top_idx] = ret_addr;
      end else if (do_pop) begin
        ras_ptr_d = top_idx;
        ras_cnt_d = ras_cnt_q - cnt_w'(1);
      end else if (bus.link) begin
        ras_mem_d[ras_ptr_q] = ret_addr;
        ras_ptr_d            = ras_ptr_q + ptr_w'(1);
        if (!ras_full) ras_cnt_d = ras_cnt_q + cnt_w'(1);
      end
    end else if (bus.flush || bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q     <= 1'b0;
      jump_target_q   <= '0;
      misaligned_q    <= 1'b0;
      ras_underflow_q <= 1'b0;
      ras_overflow_q  <= 1'b0;
      ras_ptr_q       <= '0;
      ras_cnt_q       <= '0;
      ras_mem_q       <= '{default: '0};
    end else begin
      out_valid_q     <= out_valid_d;
      jump_target_q   <= jump_target_d;
      misaligned_q    <= misaligned_d;
      ras_underflow_q <= ras_underflow_d;
      ras_overflow_q  <= ras_overflow_d;
      ras_ptr_q       <= ras_ptr_d;
      ras_cnt_q       <= ras_cnt_d;
      ras_mem_q       <= ras_mem_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.jump_target   = jump_target_q;
  assign bus.misaligned    = misaligned_q;
  assign bus.ras_underflow = ras_underflow_q;
  assign bus.ras_overflow  = ras_overflow_q;
endmodule
